// File: rtl/b8to3_enb_irq_encoder_pkg.sv
// Shared constants and types for the 8-to-3 request encoder and the
// companion 3-to-8 decoder family.
//   REQ_W    : number of request lines
//   CODE_W   : width of the binary request code
//   state_t  : grant FSM state encoding
//   code_to_onehot : expands a code back to a one-hot request mask
package b8to3_enb_irq_encoder_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SERV = 1'b1
    } state_t;

    function automatic logic [REQ_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [REQ_W-1:0] mask;
        mask = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/b8to3_enb_irq_encoder_if.sv
// Request/grant bus between peripheral request lines, the encoder and the
// consumer.
//   x7_x0       : request lines
//   e           : request latch enable
//   ack         : consumer acknowledge of the presented code
//   z2_z0       : code being served
//   v           : code valid
//   pend7_pend0 : pending register, debug/status
// master = request source and consumer side, slave = encoder.
interface b8to3_enb_irq_encoder_if;
    import b8to3_enb_irq_encoder_pkg::*;

    logic [REQ_W-1:0]  x7_x0;
    logic              e;
    logic              ack;
    logic [CODE_W-1:0] z2_z0;
    logic              v;
    logic [REQ_W-1:0]  pend7_pend0;

    modport master (
        output x7_x0,
        output e,
        output ack,
        input  z2_z0,
        input  v,
        input  pend7_pend0
    );

    modport slave (
        input  x7_x0,
        input  e,
        input  ack,
        output z2_z0,
        output v,
        output pend7_pend0
    );

endinterface

// File: rtl/b8to3_prio_encoder.sv
// Combinational 8-to-3 fixed-priority encoder.
//   req  : request vector
//   code : index of the winning request (0 when none)
//   any  : at least one request set
// HI_FIRST=1 gives bit 7 the highest priority, HI_FIRST=0 gives bit 0.
module b8to3_prio_encoder
    import b8to3_enb_irq_encoder_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    // Scan towards the highest-priority end so the last hit wins.
    always_comb begin
        code = '0;
        any  = |req;
        if (HI_FIRST) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (req[i]) code = i[CODE_W-1:0];
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (req[i]) code = i[CODE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/b8to3_enb_irq_encoder.sv
// Registered 8-to-3 request encoder with valid/ack handshake.
//   clock  : rising-edge clock
//   reset_ : asynchronous active-low reset
//   bus    : request/grant bus (slave side), see b8to3_enb_irq_encoder_if
// Requests accumulate in a pending register; one is picked by fixed
// priority and its code is held until acknowledged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | v=0, waiting for any pending bit; picks prio(P) when seen
// ST_SERV | v=1, code frozen until ack, then its pending bit clears
module b8to3_enb_irq_encoder
    import b8to3_enb_irq_encoder_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_,
    b8to3_enb_irq_encoder_if.slave        bus
);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [REQ_W-1:0]  pend_q, pend_d;
    logic [REQ_W-1:0]  clr;
    logic [CODE_W-1:0] pe_code;
    logic              pe_any;

    b8to3_prio_encoder #(
        .HI_FIRST (HI_FIRST)
    ) u_prio (
        .req  (pend_q),
        .code (pe_code),
        .any  (pe_any)
    );

    // Clear and set are applied in one expression with set last, so a
    // request held across its own ack edge stays pending.
    always_comb begin
        clr = '0;
        if (state_q == ST_SERV && bus.ack) clr = code_to_onehot(code_q);
        pend_d = (pend_q & ~clr) | (bus.x7_x0 & {REQ_W{bus.e}});
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (pe_any) begin
                    code_d  = pe_code;
                    state_d = ST_SERV;
                end
            end
            ST_SERV: begin
                if (bus.ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.v           = (state_q == ST_SERV);
    assign bus.z2_z0       = code_q;
    assign bus.pend7_pend0 = pend_q;

endmodule
